// File: rtl/image_fetch_ctrl.sv
// Image fetch controller: reads images from a 1-cycle-latency RAM and streams them over a
// valid/ready handshake. Define IMG_FETCH_LOOP_EN to repeat the run until stop.
module image_fetch_ctrl #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 784
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH:0]   img_count,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] img_data,
  output logic                  img_valid,
  input  logic                  img_ready,
  output logic [ADDR_WIDTH-1:0] img_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StHold, StFin} state_e;

  localparam logic [ADDR_WIDTH:0] One = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  // One bit wider than the address so a full 2^ADDR_WIDTH run terminates cleanly.
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] index_q, index_d;
  logic                  valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      index_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      data_q  <= data_d;
      index_q <= index_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    data_d  = data_q;
    index_d = index_q;
    valid_d = valid_q;
    case (state_q)
      StIdle: begin
        if (start && !stop) begin
          count_d = img_count;
          idx_d   = '0;
          state_d = (img_count == '0) ? StFin : StRd;
        end
      end
      StRd:   state_d = StCap;
      StCap: begin
        data_d  = ram_dout;
        index_d = idx_q[ADDR_WIDTH-1:0];
        valid_d = 1'b1;
        state_d = StHold;
      end
      StHold: begin
        if (valid_q && img_ready) begin
          valid_d = 1'b0;
          if (idx_q == count_q - One) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + One;
            state_d = StRd;
          end
        end
      end
      StFin: begin
`ifdef IMG_FETCH_LOOP_EN
        // A zero-length run has nothing to repeat, so it still ends in idle.
        if (count_q != '0) begin
          idx_d   = '0;
          state_d = StRd;
        end else begin
          state_d = StIdle;
        end
`else
        state_d = StIdle;
`endif
      end
      default: state_d = StIdle;
    endcase
    // Abort wins over any same-cycle transfer or state advance.
    if (stop && (state_q != StIdle)) begin
      state_d = StIdle;
      valid_d = 1'b0;
    end
  end

  assign ram_en    = (state_q == StRd);
  assign ram_we    = 1'b0;
  assign ram_addr  = (state_q == StRd) ? idx_q[ADDR_WIDTH-1:0] : '0;
  assign img_data  = data_q;
  assign img_valid = valid_q;
  assign img_index = index_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);

endmodule

// File: tb/tb_image_fetch_ctrl.sv
// Directed self-checking bench for image_fetch_ctrl with a 1-cycle-latency RAM model.
module tb_image_fetch_ctrl;

  localparam int unsigned AW = 11;
  localparam int unsigned DW = 784;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, img_ready;
  logic [AW:0]   img_count;
  logic          ram_en, ram_we, img_valid, busy, done;
  logic [AW-1:0] ram_addr, img_index;
  logic [DW-1:0] ram_dout, img_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int n_bad = 0;
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] xfer_q[$];

  image_fetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .img_count(img_count),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .img_data(img_data), .img_valid(img_valid), .img_ready(img_ready),
    .img_index(img_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    logic [DW-1:0] p;
    p = '0;
    p[15:0] = 16'h5A00 ^ {{(16 - AW){1'b0}}, a};
    p[DW-1 -: 16] = ~{{(16 - AW){1'b0}}, a};
    return p;
  endfunction

  // Out-of-range reads return a sentinel no valid address can match.
  function automatic logic [AW:0] q_at(input logic [AW-1:0] q[$], input int i);
    return (i < q.size()) ? {1'b0, q[i]} : {(AW + 1){1'b1}};
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= pat(ram_addr);
      rd_q.push_back(ram_addr);
    end
    if (img_valid && img_ready) begin
      xfer_q.push_back(img_index);
      if (img_data !== pat(img_index)) n_bad++;
    end
    if (done) n_done++;
  end

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rd_q.delete();
    xfer_q.delete();
    n_done = 0;
    n_bad  = 0;
  endtask

  // Returns at the negedge right after the edge that samples start.
  task automatic kick(input int cnt);
    @(negedge clk);
    img_count = (AW + 1)'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, done, 1);
    @(negedge clk);
  endtask

  initial begin
    int fv, dk, k;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; img_ready = 1'b0; img_count = '0;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_valid", img_valid, 0);
    check_val("rst_ram_en", ram_en, 0);
    check_val("rst_ram_addr", ram_addr, 0);
    check_val("rst_index", img_index, 0);
    check_val("rst_data", img_data, 0);
    check_val("ram_we", ram_we, 0);
    rst_n = 1'b1;

`ifndef IMG_FETCH_LOOP_EN
    // Basic run of three images with ready held high.
    clear_log();
    img_ready = 1'b1;
    kick(3);
    fv = -1; dk = -1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (img_valid && fv < 0) fv = i;
      if (done) dk = i;
    end
    check_val("basic_first_valid", fv, 2);
    check_val("basic_done_cycle", dk, 9);
    check_val("basic_rd_n", rd_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check_val("basic_addr", q_at(rd_q, i), i);
      check_val("basic_xidx", q_at(xfer_q, i), i);
    end
    check_val("basic_data", n_bad, 0);
    check_val("basic_ndone", n_done, 1);
    check_val("basic_busy_end", busy, 0);

    // Backpressure: hold image 0 for five cycles.
    clear_log();
    img_ready = 1'b0;
    kick(2);
    k = 0;
    while (!img_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("bp_valid", img_valid, 1);
      check_val("bp_index", img_index, 0);
      check_val("bp_data", img_data, pat(0));
    end
    check_val("bp_rd_n", rd_q.size(), 1);
    img_ready = 1'b1;
    @(negedge clk);
    img_ready = 1'b0;
    check_val("bp_valid_drop", img_valid, 0);
    img_ready = 1'b1;
    wait_done("bp_done", 20);
    check_val("bp_xfer_n", xfer_q.size(), 2);
    check_val("bp_xidx1", q_at(xfer_q, 1), 1);
    check_val("bp_rd_n2", rd_q.size(), 2);
    check_val("bp_xdata", n_bad, 0);

    // Zero count.
    clear_log();
    kick(0);
    check_val("zero_done", done, 1);
    check_val("zero_valid", img_valid, 0);
    @(negedge clk);
    check_val("zero_done_off", done, 0);
    check_val("zero_busy", busy, 0);
    check_val("zero_rd_n", rd_q.size(), 0);
    check_val("zero_ndone", n_done, 1);

    // Abort during HOLD of image 1 of 4, stop coinciding with ready.
    clear_log();
    img_ready = 1'b1;
    kick(4);
    k = 0;
    while (!(img_valid && img_index == 1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("abort_reach", img_index, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_val("abort_busy", busy, 0);
    check_val("abort_valid", img_valid, 0);
    repeat (4) @(negedge clk);
    check_val("abort_ndone", n_done, 0);
    check_val("abort_rd_n", rd_q.size(), 2);
    clear_log();
    kick(1);
    wait_done("restart_done", 10);
    check_val("restart_addr0", q_at(rd_q, 0), 0);
    check_val("restart_rd_n", rd_q.size(), 1);

    // Asynchronous reset during RD, off the clock edge.
    clear_log();
    kick(3);
    check_val("ar_in_rd", ram_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("ar_ram_en", ram_en, 0);
    check_val("ar_busy", busy, 0);
    check_val("ar_valid", img_valid, 0);
    check_val("ar_index", img_index, 0);
    check_val("ar_data", img_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check_val("ar_ndone", n_done, 0);
    check_val("ar_busy_after", busy, 0);

    // Start and count changes while busy are ignored.
    clear_log();
    kick(2);
    start = 1'b1;
    img_count = 12'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_done", 20);
    check_val("busy_xfer_n", xfer_q.size(), 2);
    check_val("busy_idle", busy, 0);

    // Full address range: 2^AW images.
    clear_log();
    kick(1 << AW);
    wait_done("full_done", 7000);
    check_val("full_rd_n", rd_q.size(), 1 << AW);
    check_val("full_last_addr", q_at(rd_q, (1 << AW) - 1), (1 << AW) - 1);
    check_val("full_xfer_n", xfer_q.size(), 1 << AW);
    check_val("full_last_idx", q_at(xfer_q, (1 << AW) - 1), (1 << AW) - 1);
    check_val("full_data", n_bad, 0);
`else
    // Looping run of two images until stop.
    clear_log();
    img_ready = 1'b1;
    kick(2);
    repeat (16) @(negedge clk);
    check_val("loop_busy", busy, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check_val("loop_stop_busy", busy, 0);
    check_val("loop_stop_valid", img_valid, 0);
    repeat (3) @(negedge clk);
    check_val("loop_ndone", n_done, 2);
    check_val("loop_rd_n", rd_q.size(), 5);
    for (int i = 0; i < 5; i++) check_val("loop_addr", q_at(rd_q, i), i % 2);
    check_val("loop_data", n_bad, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
